// File: rtl/led_pkg.sv
// Shared definitions for the LED drive path: command encodings, FSM states,
// the default 1 ms time base and small state-decode helpers.
package led_pkg;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_FLASH = 2'b11;

  localparam int TICK_DIV_1MS = 20000;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_ON      = 3'd1,
    S_BLK_ON  = 3'd2,
    S_BLK_OFF = 3'd3,
    S_FL_ON   = 3'd4,
    S_FL_OFF  = 3'd5
  } led_state_t;

  function automatic logic state_lit(input led_state_t s);
    case (s)
      S_ON, S_BLK_ON, S_FL_ON: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic state_busy(input led_state_t s);
    case (s)
      S_FL_ON, S_FL_OFF: return 1'b1;
      default:           return 1'b0;
    endcase
  endfunction

  // States whose duration is measured by the phase counter.
  function automatic logic state_timed(input led_state_t s);
    case (s)
      S_BLK_ON, S_BLK_OFF, S_FL_ON, S_FL_OFF: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ms_tick.sv
// Time-base divider: registered one-cycle tick every TICK_DIV cycles,
// restartable with clr so the next tick lands a full period later.
module ms_tick
  import led_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_1MS
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic          tick_r;

  // Next divider count: restart on clr, wrap at the terminal value.
  always_comb begin
    cnt_s = cnt_r;
    if (clr) begin
      cnt_s = {CW{1'b0}};
    end else if (cnt_r == CW'(TICK_DIV - 1)) begin
      cnt_s = {CW{1'b0}};
    end else begin
      cnt_s = cnt_r + CW'(1);
    end
  end

  // Divider and tick registers; tick is high while the count sits at its last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= {CW{1'b0}};
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_s;
      tick_r <= (cnt_s == CW'(TICK_DIV - 1));
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/led_driver.sv
// LED waveform generator: off / on / blink / N flashes with a done pulse.
// Optional LED_ACTIVE_LOW_EN inverts the led pin (lit = 0, reset value 1).
module led_driver
  import led_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_1MS,
  parameter int HALF_MS  = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic [3:0] cmd_count,
  output logic       busy,
  output logic       done,
  output logic       led
);

  localparam int PH_W = $clog2(HALF_MS + 1);

`ifdef LED_ACTIVE_LOW_EN
  localparam logic LED_LIT = 1'b0;
`else
  localparam logic LED_LIT = 1'b1;
`endif

  led_state_t      state_r;
  led_state_t      state_s;
  logic [PH_W-1:0] phase_r;
  logic [PH_W-1:0] phase_s;
  logic [3:0]      rem_r;
  logic [3:0]      rem_s;
  logic            done_s;
  logic            done_r;
  logic            busy_r;
  logic            ready_r;
  logic            led_r;
  logic            accept_s;
  logic            tick_s;
  logic            phase_end_s;

  assign accept_s    = cmd_valid && ready_r;
  assign phase_end_s = tick_s && (phase_r == PH_W'(HALF_MS - 1));

  ms_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (accept_s),
    .tick  (tick_s)
  );

  // Next-state, phase and flash-count logic; an accepted command always wins.
  always_comb begin
    state_s = state_r;
    phase_s = phase_r;
    rem_s   = rem_r;
    done_s  = 1'b0;
    if (accept_s) begin
      phase_s = {PH_W{1'b0}};
      case (cmd_mode)
        MODE_OFF:   state_s = S_OFF;
        MODE_ON:    state_s = S_ON;
        MODE_BLINK: state_s = S_BLK_ON;
        MODE_FLASH: begin
          if (cmd_count == 4'd0) begin
            state_s = S_OFF;
            rem_s   = 4'd0;
            done_s  = 1'b1;
          end else begin
            state_s = S_FL_ON;
            rem_s   = cmd_count;
          end
        end
        default:    state_s = S_OFF;
      endcase
    end else begin
      if (state_timed(state_r) && tick_s) begin
        if (phase_end_s) begin
          phase_s = {PH_W{1'b0}};
        end else begin
          phase_s = phase_r + PH_W'(1);
        end
      end else begin
        phase_s = phase_r;
      end
      case (state_r)
        S_OFF:     state_s = S_OFF;
        S_ON:      state_s = S_ON;
        S_BLK_ON:  state_s = phase_end_s ? S_BLK_OFF : S_BLK_ON;
        S_BLK_OFF: state_s = phase_end_s ? S_BLK_ON : S_BLK_OFF;
        S_FL_ON:   state_s = phase_end_s ? S_FL_OFF : S_FL_ON;
        S_FL_OFF: begin
          if (phase_end_s) begin
            // Last flash when one (or, defensively, zero) remains.
            if ((rem_r == 4'd1) || (rem_r == 4'd0)) begin
              state_s = S_OFF;
              rem_s   = 4'd0;
              done_s  = 1'b1;
            end else begin
              state_s = S_FL_ON;
              rem_s   = rem_r - 4'd1;
            end
          end else begin
            state_s = S_FL_OFF;
          end
        end
        default:   state_s = S_OFF;
      endcase
    end
  end

  // State, counters and outputs; outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_OFF;
      phase_r <= {PH_W{1'b0}};
      rem_r   <= 4'd0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      ready_r <= 1'b1;
      led_r   <= ~LED_LIT;
    end else begin
      state_r <= state_s;
      phase_r <= phase_s;
      rem_r   <= rem_s;
      done_r  <= done_s;
      busy_r  <= state_busy(state_s);
      ready_r <= ~state_busy(state_s);
      led_r   <= state_lit(state_s) ? LED_LIT : ~LED_LIT;
    end
  end

  assign cmd_ready = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign led       = led_r;

endmodule

// File: tb/tb_led_driver.sv
// Bench for led_driver: vector table, hand-written corner sequences and random
// traffic checked against a time-since-accept reference model.
module tb_led_driver;
  import led_pkg::*;

  localparam int TDIV = 4;
  localparam int HALF = 3;
  localparam int P    = TDIV * HALF;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_mode = 2'b00;
  logic [3:0] cmd_count = 4'd0;
  logic       busy;
  logic       done;
  logic       led;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: last accepted command and cycles elapsed since it.
  logic [1:0] m_mode = MODE_OFF;
  int         m_n    = 0;
  int         m_t    = 1000;

  led_driver #(.TICK_DIV(TDIV), .HALF_MS(HALF)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_count (cmd_count),
    .busy      (busy),
    .done      (done),
    .led       (led)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic pin(input logic lit);
`ifdef LED_ACTIVE_LOW_EN
    return !lit;
`else
    return lit;
`endif
  endfunction

  function automatic logic exp_busy();
    return (m_mode == MODE_FLASH) && (m_t < 2 * m_n * P);
  endfunction

  function automatic logic exp_done();
    return (m_mode == MODE_FLASH) && (m_t == 2 * m_n * P);
  endfunction

  function automatic logic exp_lit();
    case (m_mode)
      MODE_ON:    return 1'b1;
      MODE_BLINK: return ((m_t / P) % 2) == 0;
      MODE_FLASH: return exp_busy() && (((m_t / P) % 2) == 0);
      default:    return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_led"},   led,       pin(exp_lit()));
    chk({tag, "_busy"},  busy,      exp_busy());
    chk({tag, "_done"},  done,      exp_done());
    chk({tag, "_ready"}, cmd_ready, !exp_busy());
  endtask

  // Drive inputs on the falling edge, advance the model across the rising edge,
  // and return #1 after it so outputs can be sampled.
  task automatic step(input logic r, input logic v, input logic [1:0] m, input logic [3:0] c);
    logic acc;
    @(negedge clk);
    reset     = r;
    cmd_valid = v;
    cmd_mode  = m;
    cmd_count = c;
    acc = v && !exp_busy() && !r;
    @(posedge clk);
    if (r) begin
      m_mode = MODE_OFF;
      m_n    = 0;
      m_t    = 1000;
    end else if (acc) begin
      m_mode = m;
      m_n    = int'(c);
      m_t    = 0;
    end else if (m_t < 100000) begin
      m_t++;
    end
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic       valid;
    logic [1:0] mode;
    logic [3:0] cnt;
    logic       e_led;
    logic       e_busy;
    logic       e_done;
    logic       e_ready;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int done_at;
    int done_hits;
    int busy_cnt;
    int pulses;
    logic prev_lit;

    vecs[0]  = '{1'b1, 1'b0, MODE_OFF,   4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, MODE_OFF,   4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, MODE_ON,    4'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, MODE_OFF,   4'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, MODE_OFF,   4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, MODE_FLASH, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, MODE_OFF,   4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, MODE_BLINK, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, MODE_OFF,   4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, MODE_FLASH, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, MODE_ON,    4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, MODE_OFF,   4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, MODE_ON,    4'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, MODE_OFF,   4'd0, 1'b0, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].rst, vecs[i].valid, vecs[i].mode, vecs[i].cnt);
      chk($sformatf("vec%0d_led", i),   led,       pin(vecs[i].e_led));
      chk($sformatf("vec%0d_busy", i),  busy,      vecs[i].e_busy);
      chk($sformatf("vec%0d_done", i),  done,      vecs[i].e_done);
      chk($sformatf("vec%0d_ready", i), cmd_ready, vecs[i].e_ready);
    end

    // Reset then 50 idle cycles.
    step(1'b1, 1'b0, MODE_OFF, 4'd0);
    check_model("rst");
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0, MODE_OFF, 4'd0);
      check_model("idle");
    end

    // ON, then OFF 30 cycles later.
    step(1'b0, 1'b1, MODE_ON, 4'd0);
    check_model("on");
    for (int i = 0; i < 29; i++) begin
      step(1'b0, 1'b0, MODE_OFF, 4'd0);
      check_model("on_hold");
    end
    step(1'b0, 1'b1, MODE_OFF, 4'd0);
    check_model("off");

    // Continuous blink for more than four periods.
    step(1'b0, 1'b1, MODE_BLINK, 4'd0);
    check_model("blink");
    for (int i = 0; i < 110; i++) begin
      step(1'b0, 1'b0, MODE_OFF, 4'd0);
      check_model("blink_run");
    end

    // FLASH 3 with an ON command held pending throughout.
    step(1'b0, 1'b1, MODE_FLASH, 4'd3);
    check_model("flash3");
    done_at   = -1;
    done_hits = 0;
    busy_cnt  = busy ? 1 : 0;
    pulses    = (led == pin(1'b1)) ? 1 : 0;
    prev_lit  = (led == pin(1'b1));
    for (int t = 1; t <= 80; t++) begin
      step(1'b0, 1'b1, MODE_ON, 4'd0);
      check_model("flash3_run");
      if (done) begin
        done_hits++;
        done_at = t;
      end
      if (busy) busy_cnt++;
      if (t <= 72 && (led == pin(1'b1)) && !prev_lit) pulses++;
      prev_lit = (led == pin(1'b1));
      if (t == 73) chk("flash3_held_on_accepted", led, pin(1'b1));
    end
    chk_int("flash3_done_at", done_at, 72);
    chk_int("flash3_done_hits", done_hits, 1);
    chk_int("flash3_busy_cycles", busy_cnt, 72);
    chk_int("flash3_pulses", pulses, 3);

    // FLASH 0: immediate done, never busy, never lit.
    step(1'b0, 1'b1, MODE_FLASH, 4'd0);
    chk("flash0_done", done, 1'b1);
    chk("flash0_busy", busy, 1'b0);
    chk("flash0_led", led, pin(1'b0));
    step(1'b0, 1'b0, MODE_OFF, 4'd0);
    check_model("flash0_after");

    // Reset at cycle 20 of FLASH 5, then ON straight after.
    step(1'b0, 1'b1, MODE_FLASH, 4'd5);
    for (int i = 1; i < 20; i++) begin
      step(1'b0, 1'b0, MODE_OFF, 4'd0);
      check_model("flash5_run");
    end
    step(1'b1, 1'b0, MODE_OFF, 4'd0);
    chk("abort_led", led, pin(1'b0));
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    step(1'b0, 1'b1, MODE_ON, 4'd0);
    chk("abort_on_led", led, pin(1'b1));
    check_model("abort_on");

    // Random traffic against the model.
    for (int i = 0; i < 900; i++) begin
      logic       r;
      logic       v;
      logic [1:0] m;
      logic [3:0] c;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 15) == 0);
      m = 2'($urandom_range(0, 3));
      c = 4'($urandom_range(0, 3));
      step(r, v, m, c);
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
